da_engine: RTL and testbench

- Parametrised distributed-arithmetic (DA) FIR inner-product engine; the next generation of the team's fixed 8-bank DA datapath.
- Holds NBANK coefficient LUT banks, each addressed by a K-bit slice of one input bit-plane, and sums bank outputs in a registered adder tree. Shift-accumulates XW bit-planes, MSB first.
- Adds over the fixed version: valid/ready plane and result handshakes, one plane per cycle throughput, runtime signed/unsigned mode, in-engine coefficient load port.
- Sits between the sample delay-line/address generator and the FIR output stage.

---
 rtl/da_pkg.sv | 17 +
 rtl/da_lut_bank.sv | 20 ++
 rtl/da_engine.sv | 103 ++++++++++
 tb/tb_da_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// da_pkg: shared state encoding and width helpers for the distributed-arithmetic engine
package da_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
  function automatic int calc_sw(input int cw, input int nbank);
    return cw + clog2(nbank);
  endfunction
  function automatic int calc_accw(input int cw, input int nbank, input int xw);
    return calc_sw(cw, nbank) + xw;
  endfunction
  localparam int SW = calc_sw(20, 8);
  localparam int ACCW = calc_accw(20, 8, 16);
endpackage

// File: rtl/da_lut_bank.sv
// da_lut_bank: one coefficient LUT bank, single write port, synchronous read
module da_lut_bank
  import da_pkg::*;
#(
  parameter int K = 8,
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [K-1:0]  waddr,
  input  logic [CW-1:0] wdata,
  input  logic [K-1:0]  raddr,
  output logic [CW-1:0] rdata
);
  logic [CW-1:0] mem [2**K];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/da_engine.sv
// da_engine: banked-LUT distributed-arithmetic inner product with pipelined adder tree and shift-accumulator
module da_engine
  import da_pkg::*;
#(
  parameter int NBANK = 8,
  parameter int K = 8,
  parameter int CW = 20,
  parameter int XW = 16,
  localparam int LOG2N = clog2(NBANK),
  localparam int SW = calc_sw(CW, NBANK),
  localparam int ACCW = calc_accw(CW, NBANK, XW)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [LOG2N-1:0]       cfg_bank,
  input  logic [K-1:0]           cfg_addr,
  input  logic [CW-1:0]          cfg_data,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   plane_valid,
  output logic                   plane_ready,
  input  logic [NBANK*K-1:0]     plane_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   busy
);
  localparam int CNTW = clog2(XW + 1);
  state_t state, state_nx;
  logic [CNTW-1:0] pcnt, acnt;
  logic smode, accept, step, last_in, last_acc;
  logic [LOG2N:0] vld;
  logic signed [ACCW-1:0] acc, ext, add;
  logic [CW-1:0] rd [NBANK];
  logic signed [SW-1:0] leaf [NBANK];
  logic signed [SW-1:0] node [NBANK-1];
  assign plane_ready = state == RUN;
  assign busy = state != IDLE;
  assign out_valid = state == HOLD;
  assign out_data = acc;
  assign accept = plane_valid && plane_ready;
  assign step = vld[LOG2N];
  assign last_in = accept && pcnt == CNTW'(XW - 1);
  assign last_acc = step && acnt == CNTW'(XW - 1);
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    da_lut_bank #(.K(K), .CW(CW)) u_bank (
      .clk  (clk),
      .we   (cfg_we && state == IDLE && cfg_bank == LOG2N'(b)),
      .waddr(cfg_addr),
      .wdata(cfg_data),
      .raddr(plane_addr[b*K +: K]),
      .rdata(rd[b])
    );
    assign leaf[b] = {{LOG2N{rd[b][CW-1]}}, rd[b]};
  end
  // Heap-ordered tree: node i sums children 2i+1/2i+2; indices past NBANK-2 are LUT leaves
  for (genvar i = 0; i < NBANK - 1; i++) begin : g_node
    logic signed [SW-1:0] l, r;
    if (2*i + 1 >= NBANK - 1) begin : g_leaf
      assign l = leaf[2*i + 2 - NBANK];
      assign r = leaf[2*i + 3 - NBANK];
    end else begin : g_inner
      assign l = node[2*i + 1];
      assign r = node[2*i + 2];
    end
    always_ff @(posedge clk) node[i] <= l + r;
  end
  assign ext = {{XW{node[0][SW-1]}}, node[0]};
  // The MSB plane carries negative weight for two's-complement samples
  assign add = (smode && acnt == '0) ? ~ext + ACCW'(1) : ext;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pcnt <= '0;
      acnt <= '0;
      smode <= 1'b0;
      vld <= '0;
      acc <= '0;
    end else begin
      state <= state_nx;
      vld <= {vld[LOG2N-1:0], accept};
      if (state == IDLE && start) begin
        smode <= signed_mode;
        pcnt <= '0;
        acnt <= '0;
        acc <= '0;
      end
      if (accept) pcnt <= pcnt + CNTW'(1);
      if (step) begin
        acc <= (acc <<< 1) + add;
        acnt <= acnt + CNTW'(1);
      end
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN ? (last_in ? DRAIN : RUN) :
               state == DRAIN ? (last_acc ? HOLD : DRAIN) :
               (out_ready ? IDLE : HOLD);
  end
endmodule

// File: tb/tb_da_engine.sv
// tb_da_engine: scoreboard bench for a small and a default-size DA engine
module tb_da_engine;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic s_we = 0, s_bank = 0, s_start = 0, s_sm = 0, s_pv = 0, s_pr, s_ov, s_ordy = 0, s_busy;
  logic [1:0] s_addr = 0;
  logic [7:0] s_data = 0;
  logic [3:0] s_pa = 0;
  logic signed [12:0] s_od;

  logic d_we = 0, d_start = 0, d_sm = 0, d_pv = 0, d_pr, d_ov, d_ordy = 0, d_busy;
  logic [2:0] d_bank = 0;
  logic [7:0] d_addr = 0;
  logic [19:0] d_data = 0;
  logic [63:0] d_pa = 0;
  logic signed [38:0] d_od;

  da_engine #(.NBANK(2), .K(2), .CW(8), .XW(4)) u_small (
    .clk(clk), .reset(reset), .cfg_we(s_we), .cfg_bank(s_bank), .cfg_addr(s_addr),
    .cfg_data(s_data), .start(s_start), .signed_mode(s_sm), .plane_valid(s_pv),
    .plane_ready(s_pr), .plane_addr(s_pa), .out_valid(s_ov), .out_ready(s_ordy),
    .out_data(s_od), .busy(s_busy)
  );
  da_engine u_def (
    .clk(clk), .reset(reset), .cfg_we(d_we), .cfg_bank(d_bank), .cfg_addr(d_addr),
    .cfg_data(d_data), .start(d_start), .signed_mode(d_sm), .plane_valid(d_pv),
    .plane_ready(d_pr), .plane_addr(d_pa), .out_valid(d_ov), .out_ready(d_ordy),
    .out_data(d_od), .busy(d_busy)
  );

  int n_chk = 0, n_fail = 0;
  longint exp_q[$];
  int lut0[4] = '{0, 3, 5, 8};
  logic [3:0] pl[4] = '{4'h1, 4'h1, 4'h3, 4'h1};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_small(input bit sgn);
    longint a = 0;
    for (int i = 0; i < 4; i++) begin
      longint s = lut0[pl[i][1:0]];
      a = (i == 0 && sgn) ? -s : 2 * a + s;
    end
    return a;
  endfunction

  task automatic load_small(input logic b, input logic [1:0] a, input logic [7:0] d);
    s_we = 1; s_bank = b; s_addr = a; s_data = d;
    tick;
    s_we = 0;
  endtask

  task automatic s_begin(input bit sgn);
    s_sm = sgn; s_start = 1;
    tick;
    s_start = 0;
  endtask

  task automatic s_stream(input int gap, input bit we_mid, output int last_cyc, output bit ok);
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      s_pa = pl[i]; s_pv = 1;
      if (!s_pr) ok = 0;
      if (we_mid && i == 0) begin s_we = 1; s_bank = 0; s_addr = 1; s_data = 8'd100; end
      tick;
      s_we = 0; s_pv = 0;
      last_cyc = cyc;
      if (i < 3) repeat (gap) tick;
    end
  endtask

  task automatic s_wait(input int budget, output int vc);
    int n = 0;
    while (!s_ov && n < budget) begin tick; n++; end
    vc = s_ov ? cyc : -1;
  endtask

  task automatic s_take;
    s_ordy = 1;
    tick;
    s_ordy = 0;
  endtask

  task automatic test_reset;
    n_chk++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b expected 0", s_ov); end
    n_chk++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
    n_chk++; if (s_pr !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", s_pr); end
    n_chk++; if (s_od !== 13'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", s_od); end
    n_chk++; if ({d_ov, d_busy, d_pr} !== 3'b000) begin n_fail++; $display("FAIL reset_def: got %b expected 000", {d_ov, d_busy, d_pr}); end
  endtask

  task automatic test_stream(input string name, input bit sgn, input int gap, input longint expv);
    int last, vc;
    bit ok;
    longint e;
    exp_q.push_back(expv);
    s_begin(sgn);
    s_stream(gap, 0, last, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_ready: plane_ready low during RUN, expected high", name); end
    s_wait(20, vc);
    n_chk++; if (vc - last !== 2) begin n_fail++; $display("FAIL %s_latency: got %0d edges expected 2", name, vc - last); end
    e = exp_q.pop_front();
    n_chk++; if (longint'(s_od) !== e) begin n_fail++; $display("FAIL %s_data: got %0d expected %0d", name, s_od, e); end
    s_take;
    n_chk++; if ({s_ov, s_busy} !== 2'b00) begin n_fail++; $display("FAIL %s_release: got ov/busy %b expected 00", name, {s_ov, s_busy}); end
  endtask

  task automatic test_hold;
    int last, vc;
    bit ok;
    longint e;
    exp_q.push_back(7);
    s_begin(1);
    s_stream(0, 0, last, ok);
    s_wait(20, vc);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      s_start = 1;
      tick;
      n_chk++; if (longint'(s_od) !== e) begin n_fail++; $display("FAIL hold_data[%0d]: got %0d expected %0d", i, s_od, e); end
      n_chk++; if ({s_ov, s_pr, s_busy} !== 3'b101) begin n_fail++; $display("FAIL hold_flags[%0d]: got ov/ready/busy %b expected 101", i, {s_ov, s_pr, s_busy}); end
    end
    s_start = 0;
    s_take;
    n_chk++; if ({s_ov, s_busy} !== 2'b00) begin n_fail++; $display("FAIL hold_release: got ov/busy %b expected 00", {s_ov, s_busy}); end
  endtask

  task automatic test_reset_mid;
    s_begin(1);
    s_pa = pl[0]; s_pv = 1;
    tick;
    s_pa = pl[1];
    tick;
    s_pv = 0;
    tick; tick;
    n_chk++; if (s_od !== -13'sd3) begin n_fail++; $display("FAIL partial_acc: got %0d expected -3", s_od); end
    reset = 1;
    #1;
    n_chk++; if ({s_ov, s_busy, s_pr} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b expected 000", {s_ov, s_busy, s_pr}); end
    n_chk++; if (s_od !== 13'd0) begin n_fail++; $display("FAIL midreset_acc: got %0d expected 0", s_od); end
    tick;
    reset = 0;
    repeat (4) tick;
    n_chk++; if ({s_ov, s_busy} !== 2'b00) begin n_fail++; $display("FAIL midreset_idle: got ov/busy %b expected 00", {s_ov, s_busy}); end
    test_stream("after_reset", 1, 0, 7);
  endtask

  task automatic test_cfg;
    int last, vc;
    bit ok;
    longint e;
    exp_q.push_back(7);
    s_begin(1);
    s_stream(0, 1, last, ok);
    s_wait(20, vc);
    e = exp_q.pop_front();
    n_chk++; if (longint'(s_od) !== e) begin n_fail++; $display("FAIL cfg_run_ignored: got %0d expected %0d", s_od, e); end
    s_take;
    s_we = 1; s_bank = 0; s_addr = 1; s_data = 8'd100; s_sm = 1; s_start = 1;
    tick;
    s_we = 0; s_start = 0;
    lut0[1] = 100;
    n_chk++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_start_busy: got %b expected 1", s_busy); end
    exp_q.push_back(model_small(1));
    s_stream(0, 0, last, ok);
    s_wait(20, vc);
    e = exp_q.pop_front();
    n_chk++; if (longint'(s_od) !== e) begin n_fail++; $display("FAIL cfg_idle_write: got %0d expected %0d", s_od, e); end
    s_take;
  endtask

  task automatic test_default;
    int last = 0, n = 0;
    longint e;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 8; b++) begin
        d_we = 1; d_bank = 3'(b); d_addr = 8'(a); d_data = 20'($countones(8'(a)));
        tick;
      end
    d_we = 0;
    exp_q.push_back(-64);
    d_sm = 1; d_start = 1;
    tick;
    d_start = 0;
    d_pa = '1; d_pv = 1;
    for (int i = 0; i < 16; i++) tick;
    d_pv = 0;
    last = cyc;
    while (!d_ov && n < 30) begin tick; n++; end
    n_chk++; if (!d_ov || cyc - last !== 4) begin n_fail++; $display("FAIL def_latency: got ov=%b after %0d edges expected 4", d_ov, cyc - last); end
    e = exp_q.pop_front();
    n_chk++; if (longint'(d_od) !== e) begin n_fail++; $display("FAIL def_data: got %0d expected %0d", d_od, e); end
    d_ordy = 1;
    tick;
    d_ordy = 0;
    n_chk++; if ({d_ov, d_busy} !== 2'b00) begin n_fail++; $display("FAIL def_release: got %b expected 00", {d_ov, d_busy}); end
  endtask

  initial begin
    tick; tick;
    reset = 0;
    tick;
    test_reset;
    for (int a = 0; a < 4; a++) begin
      load_small(0, 2'(a), 8'(lut0[a]));
      load_small(1, 2'(a), 8'd0);
    end
    test_stream("signed", 1, 0, 7);
    test_stream("unsigned", 0, 0, 55);
    test_stream("gaps", 1, 2, 7);
    test_hold;
    test_reset_mid;
    test_cfg;
    test_default;
    n_chk++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
